// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over imem req/ready, holds on stall, kills on redirect.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count/wait_count outputs.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] instr_out,
  output logic [15:0] pcplus2_out,
  output logic        fetch_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] wait_count
`endif
);

  localparam int unsigned XLEN = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [XLEN-1:0]   kill_addr_q, kill_addr_d;
  logic [XLEN-1:0]   hold_instr_q, hold_instr_d;
  logic [XLEN-1:0]   hold_pc2_q, hold_pc2_d;
  logic [XLEN-1:0]   pc_plus2;
  logic [XLEN-1:0]   target;

  assign pc_plus2 = pc_q + XLEN'(2);
  assign target   = redirect_pc & ~XLEN'(1);

  // State register; kill_addr keeps the outstanding address stable while pc already points at the target
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      kill_addr_q  <= RESET_PC;
      hold_instr_q <= NOP_INSTR;
      hold_pc2_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      kill_addr_q  <= kill_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc2_q   <= hold_pc2_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    kill_addr_d  = kill_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc2_d   = hold_pc2_q;
    imem_req     = 1'b0;
    imem_addr    = kill_q ? kill_addr_q : pc_q;
    instr_out    = NOP_INSTR;
    pcplus2_out  = '0;
    fetch_valid  = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_d = target;
          if (imem_ready) begin
            kill_d = 1'b0;
          end else begin
            if (!kill_q) kill_addr_d = pc_q;
            kill_d = 1'b1;
          end
        end else if (imem_ready) begin
          if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            fetch_valid = 1'b1;
            instr_out   = imem_rdata;
            pcplus2_out = pc_plus2;
            if (stall) begin
              hold_instr_d = imem_rdata;
              hold_pc2_d   = pc_plus2;
              state_d      = HOLD;
            end else begin
              pc_d = pc_plus2;
            end
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = REQ;
        end else begin
          fetch_valid = 1'b1;
          instr_out   = hold_instr_q;
          pcplus2_out = hold_pc2_q;
          if (!stall) begin
            pc_d    = pc_plus2;
            state_d = REQ;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic accept;
  logic wait_cyc;

  assign accept   = !redirect && !stall &&
                    (((state_q == REQ) && imem_ready && !kill_q) || (state_q == HOLD));
  assign wait_cyc = (state_q == REQ) && !imem_ready;

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
      wait_count  <= '0;
    end else begin
      if (accept && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
      if (wait_cyc && (wait_count != 16'hFFFF)) wait_count <= wait_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: wait-state memory responder, transaction-level reference model
// checked every cycle, and hand-computed literal expectations per scenario.
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP    = 16'hFFFF;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] instr_out;
  logic [15:0] pcplus2_out;
  logic        fetch_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] wait_count;
`endif

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .instr_out   (instr_out),
    .pcplus2_out (pcplus2_out),
    .fetch_valid (fetch_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .wait_count  (wait_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned wait_n;
  int unsigned waited;

  logic        s_req;
  logic        s_valid;
  logic [15:0] s_addr;
  logic [15:0] s_instr;
  logic [15:0] s_pc2;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0020) return 16'h1234;
    return {a[7:0], a[15:8]} ^ 16'h3C00;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, answer the request from the wait-state memory, snapshot outputs
  task automatic cyc(input logic s, input logic r, input logic [15:0] t);
    logic fired;
    logic req_b;
    stall       = s;
    redirect    = r;
    redirect_pc = t;
    #1;
    imem_ready = imem_req && (waited == wait_n);
    imem_rdata = imem_req ? mem_word(imem_addr) : 16'hDEAD;
    #2;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_instr = instr_out;
    s_pc2   = pcplus2_out;
    s_valid = fetch_valid;
    fired   = imem_req && imem_ready;
    req_b   = imem_req;
    @(posedge clk);
    if (fired) waited = 0;
    else if (req_b) waited++;
    #1;
  endtask

  // Reference model: the next address to fetch, an optional held instruction, and an optional
  // response owed by memory that must be thrown away
  logic        m_started;
  logic [15:0] m_pc;
  logic        m_drop;
  logic [15:0] m_drop_addr;
  logic        m_held;
  logic [15:0] m_hinstr;
  logic [15:0] m_hpc2;
  int unsigned m_fetch;
  int unsigned m_wait;
  logic        e_req;
  logic        e_valid;
  logic [15:0] e_addr;
  logic [15:0] e_instr;
  logic [15:0] e_pc2;
  logic [15:0] tgt;

  always @(negedge clk) begin
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, (m_fetch > 32'hFFFF) ? 16'hFFFF : 16'(m_fetch));
    chk("wait_count", wait_count, (m_wait > 32'hFFFF) ? 16'hFFFF : 16'(m_wait));
`endif
    e_req   = 1'b0;
    e_valid = 1'b0;
    e_addr  = m_pc;
    e_instr = NOP;
    e_pc2   = 16'h0000;
    tgt     = {redirect_pc[15:1], 1'b0};
    if (!reset_n) begin
      m_started = 1'b0;
      m_pc      = RST_PC;
      m_drop    = 1'b0;
      m_held    = 1'b0;
      m_fetch   = 0;
      m_wait    = 0;
      e_addr    = RST_PC;
      chk("m_rst_addr", imem_addr, e_addr);
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_held) begin
      if (redirect) begin
        m_pc   = tgt;
        m_held = 1'b0;
      end else begin
        e_valid = 1'b1;
        e_instr = m_hinstr;
        e_pc2   = m_hpc2;
        if (!stall) begin
          m_pc   = m_pc + 16'd2;
          m_held = 1'b0;
          m_fetch++;
        end
      end
    end else begin
      e_req  = 1'b1;
      e_addr = m_drop ? m_drop_addr : m_pc;
      chk("m_addr", imem_addr, e_addr);
      if (!imem_ready) m_wait++;
      if (redirect) begin
        if (imem_ready) m_drop = 1'b0;
        else begin
          if (!m_drop) m_drop_addr = m_pc;
          m_drop = 1'b1;
        end
        m_pc = tgt;
      end else if (imem_ready) begin
        if (m_drop) m_drop = 1'b0;
        else begin
          e_valid = 1'b1;
          e_instr = mem_word(m_pc);
          e_pc2   = m_pc + 16'd2;
          if (stall) begin
            m_held   = 1'b1;
            m_hinstr = e_instr;
            m_hpc2   = e_pc2;
          end else begin
            m_pc = m_pc + 16'd2;
            m_fetch++;
          end
        end
      end
    end
    chk("m_req", 16'(imem_req), 16'(e_req));
    chk("m_valid", 16'(fetch_valid), 16'(e_valid));
    chk("m_instr", instr_out, e_instr);
    chk("m_pc2", pcplus2_out, e_pc2);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_ready = 1'b0; imem_rdata = 16'h0000; wait_n = 0; waited = 0;
    m_started = 1'b0; m_pc = RST_PC; m_drop = 1'b0; m_drop_addr = 16'h0000;
    m_held = 1'b0; m_hinstr = NOP; m_hpc2 = 16'h0000; m_fetch = 0; m_wait = 0;
    @(posedge clk); #1;
    chk("rst_req", 16'(imem_req), 16'h0000);
    chk("rst_valid", 16'(fetch_valid), 16'h0000);
    chk("rst_instr", instr_out, 16'hFFFF);
    chk("rst_pc2", pcplus2_out, 16'h0000);
    cyc(0, 0, 0); cyc(0, 0, 0);
    reset_n = 1'b1;

    // Zero-wait boot: IDLE cycle, then back-to-back fetches
    cyc(0, 0, 0);
    chk("boot_idle_req", 16'(s_req), 16'h0000);
    cyc(0, 0, 0);
    chk("zw_addr0", s_addr, 16'h0000); chk("zw_pc2_0", s_pc2, 16'h0002);
    chk("zw_instr0", s_instr, 16'h3C00); chk("zw_valid0", 16'(s_valid), 16'h0001);
    cyc(0, 0, 0);
    chk("zw_addr1", s_addr, 16'h0002); chk("zw_pc2_1", s_pc2, 16'h0004);
    cyc(0, 0, 0);
    chk("zw_addr2", s_addr, 16'h0004); chk("zw_pc2_2", s_pc2, 16'h0006);

    // Two wait states at 0010
    cyc(0, 1, 16'h0010);
    chk("redir_valid", 16'(s_valid), 16'h0000);
    wait_n = 2;
    cyc(0, 0, 0);
    chk("ws_addr_a", s_addr, 16'h0010); chk("ws_valid_a", 16'(s_valid), 16'h0000);
    chk("ws_instr_a", s_instr, 16'hFFFF);
    cyc(0, 0, 0);
    chk("ws_addr_b", s_addr, 16'h0010); chk("ws_req_b", 16'(s_req), 16'h0001);
    cyc(0, 0, 0);
    chk("ws_valid_c", 16'(s_valid), 16'h0001); chk("ws_instr_c", s_instr, 16'h2C00);
    chk("ws_pc2_c", s_pc2, 16'h0012);
    wait_n = 0;

    // Stall for 3 cycles as 1234 arrives from 0020 (bit 0 of the target is ignored)
    cyc(0, 1, 16'h0021);
    cyc(1, 0, 0);
    chk("st_instr", s_instr, 16'h1234); chk("st_pc2", s_pc2, 16'h0022);
    for (int i = 0; i < 3; i++) begin
      cyc(i < 2, 0, 0);
      chk("hold_req", 16'(s_req), 16'h0000); chk("hold_instr", s_instr, 16'h1234);
      chk("hold_pc2", s_pc2, 16'h0022); chk("hold_valid", 16'(s_valid), 16'h0001);
    end
    cyc(0, 0, 0);
    chk("after_hold_addr", s_addr, 16'h0022); chk("after_hold_req", 16'(s_req), 16'h0001);

    // Redirect to 0100 while a 2-wait fetch of 0040 is outstanding
    cyc(0, 1, 16'h0040);
    wait_n = 2;
    cyc(0, 1, 16'h0100);
    chk("k_addr_a", s_addr, 16'h0040); chk("k_valid_a", 16'(s_valid), 16'h0000);
    cyc(0, 0, 0);
    chk("k_addr_b", s_addr, 16'h0040);
    cyc(0, 0, 0);
    chk("k_addr_c", s_addr, 16'h0040); chk("k_valid_c", 16'(s_valid), 16'h0000);
    wait_n = 0;
    cyc(0, 0, 0);
    chk("k_addr_d", s_addr, 16'h0100); chk("k_instr_d", s_instr, 16'h3C01);
    chk("k_pc2_d", s_pc2, 16'h0102);

    // Second redirect while the first kill is still pending
    wait_n = 2;
    cyc(0, 1, 16'h0200);
    chk("kk_addr_a", s_addr, 16'h0102);
    cyc(0, 1, 16'h0303);
    chk("kk_addr_b", s_addr, 16'h0102);
    cyc(0, 0, 0);
    chk("kk_valid_c", 16'(s_valid), 16'h0000);
    wait_n = 0;
    cyc(0, 0, 0);
    chk("kk_addr_d", s_addr, 16'h0302);

    // Redirect and stall together while holding
    cyc(1, 0, 0);
    chk("rs_hold_pc2", s_pc2, 16'h0306);
    cyc(1, 1, 16'h0400);
    chk("rs_valid", 16'(s_valid), 16'h0000); chk("rs_req", 16'(s_req), 16'h0000);
    chk("rs_instr", s_instr, 16'hFFFF);
    cyc(0, 0, 0);
    chk("rs_addr", s_addr, 16'h0400);

    // PC wrap at FFFE
    cyc(0, 1, 16'hFFFF);
    cyc(0, 0, 0);
    chk("wr_addr", s_addr, 16'hFFFE); chk("wr_pc2", s_pc2, 16'h0000);
    chk("wr_valid", 16'(s_valid), 16'h0001);
    cyc(0, 0, 0);
    chk("wr_next", s_addr, 16'h0000);

    // Asynchronous reset in the middle of a waiting request
    wait_n = 3;
    cyc(0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_req", 16'(imem_req), 16'h0000); chk("mr_valid", 16'(fetch_valid), 16'h0000);
    chk("mr_instr", instr_out, 16'hFFFF); chk("mr_pc2", pcplus2_out, 16'h0000);
    chk("mr_addr", imem_addr, RST_PC);
    waited = 0; wait_n = 0; imem_ready = 1'b0;
    @(posedge clk); #1;
    cyc(0, 0, 0);
    reset_n = 1'b1;
    cyc(0, 0, 0);
    chk("mr_boot_req", 16'(s_req), 16'h0000);
    cyc(0, 0, 0);
    chk("mr_addr0", s_addr, 16'h0000); chk("mr_valid0", 16'(s_valid), 16'h0001);
    cyc(0, 0, 0); cyc(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
